// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter and strobe sequencer for an async SRAM
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              sram_cs_n,
    output logic              sram_rd_n,
    output logic              sram_wr_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_din,
    output logic              busy
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;
    logic              gnt_b_q, gnt_b_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            gnt_b_q   <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            gnt_b_q   <= gnt_b_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        gnt_b_d   = gnt_b_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        cs_n_d    = cs_n_q;
        rd_n_d    = rd_n_q;
        wr_n_d    = wr_n_q;
        oe_d      = oe_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        a_ack_d   = a_ack_q;
        b_ack_d   = b_ack_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        pick_b    = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // B wins only when A is absent or A was the last one served
                    pick_b   = b_req && (!a_req || !last_b_q);
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = pick_b ? b_we : a_we;
                    addr_d   = pick_b ? b_addr : a_addr;
                    dout_d   = pick_b ? b_wdata : a_wdata;
                    cs_n_d   = 1'b0;
                    oe_d     = pick_b ? b_we : a_we;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (we_q) begin
                    wr_n_d = 1'b0;
                end else begin
                    rd_n_d = 1'b0;
                end
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rd_n_d = 1'b1;
                    wr_n_d = 1'b1;
                    if (gnt_b_q) begin
                        b_ack_d = 1'b1;
                        if (!we_q) b_rdata_d = sram_din;
                    end else begin
                        a_ack_d = 1'b1;
                        if (!we_q) a_rdata_d = sram_din;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                a_ack_d = 1'b0;
                b_ack_d = 1'b0;
                cs_n_d  = 1'b1;
                oe_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign a_rdata   = a_rdata_q;
    assign a_ack     = a_ack_q;
    assign b_rdata   = b_rdata_q;
    assign b_ack     = b_ack_q;
    assign sram_cs_n = cs_n_q;
    assign sram_rd_n = rd_n_q;
    assign sram_wr_n = wr_n_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;
    assign sram_oe   = oe_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized and directed bench for sram_arbiter with SRAM models
`timescale 1ns/1ps
module tb_sram_arbiter;
    int checks = 0;
    int failures = 0;

    logic        clk = 0, clk3 = 0, rst = 1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [17:0] a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic [15:0] a_rdata, b_rdata, sram_dout, sram_din;
    logic        a_ack, b_ack, sram_cs_n, sram_rd_n, sram_wr_n, sram_oe, busy;
    logic [17:0] sram_addr;

    logic        a3_req = 0, a3_we = 0, b3_req = 0, b3_we = 0;
    logic [17:0] a3_addr = 0, b3_addr = 0;
    logic [15:0] a3_wdata = 0, b3_wdata = 0;
    logic [15:0] a3_rdata, b3_rdata, sram3_dout, sram3_din;
    logic        a3_ack, b3_ack, sram3_cs_n, sram3_rd_n, sram3_wr_n, sram3_oe, busy3;
    logic [17:0] sram3_addr;

    logic [15:0] mem1 [0:262143];
    logic [15:0] mem3 [0:262143];
    logic [15:0] ref_mem [logic [17:0]];
    int          cyc = 0, cyc3 = 0;
    bit          ack_port_q [$];
    int          ack_cyc_q [$];

    always #10  clk  = ~clk;
    always #2.5 clk3 = ~clk3;
    always @(posedge clk)  cyc  <= cyc + 1;
    always @(posedge clk3) cyc3 <= cyc3 + 1;

    sram_arbiter #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
        .sram_cs_n(sram_cs_n), .sram_rd_n(sram_rd_n), .sram_wr_n(sram_wr_n), .sram_addr(sram_addr),
        .sram_dout(sram_dout), .sram_oe(sram_oe), .sram_din(sram_din), .busy(busy)
    );

    sram_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk3), .rst(rst),
        .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata), .a_rdata(a3_rdata), .a_ack(a3_ack),
        .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata), .b_rdata(b3_rdata), .b_ack(b3_ack),
        .sram_cs_n(sram3_cs_n), .sram_rd_n(sram3_rd_n), .sram_wr_n(sram3_wr_n), .sram_addr(sram3_addr),
        .sram_dout(sram3_dout), .sram_oe(sram3_oe), .sram_din(sram3_din), .busy(busy3)
    );

    // Asynchronous SRAM models: read data only while selected and strobed
    assign sram_din  = (!sram_cs_n && !sram_rd_n) ? mem1[sram_addr] : 16'hDEAD;
    assign sram3_din = (!sram3_cs_n && !sram3_rd_n) ? mem3[sram3_addr] : 16'hDEAD;
    always @(posedge clk)  if (!sram_cs_n && !sram_wr_n) mem1[sram_addr] <= sram_dout;
    always @(posedge clk3) if (!sram3_cs_n && !sram3_wr_n) mem3[sram3_addr] <= sram3_dout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    // Protocol monitor for the WAIT_CYCLES=1 instance
    int  wlow1 = 0, rlow1 = 0;
    bit  aprev = 0, bprev = 0;
    always @(negedge clk) begin
        if (rst) begin
            wlow1 = 0; rlow1 = 0; aprev = 0; bprev = 0;
        end else begin
            check_eq("strobe_inv", 32'({!sram_rd_n && !sram_wr_n,
                                        sram_cs_n && (!sram_rd_n || !sram_wr_n),
                                        sram_oe && !sram_rd_n, sram_oe && sram_cs_n,
                                        !sram_wr_n && !sram_oe}), 32'd0);
            check_eq("busy_cs", 32'(busy), 32'(!sram_cs_n));
            check_eq("ack_pulse", 32'((a_ack && aprev) || (b_ack && bprev) || (a_ack && b_ack)), 32'd0);
            if (!sram_wr_n) wlow1++;
            else if (wlow1 != 0) begin check_eq("wr_width", 32'(wlow1), 32'd1); wlow1 = 0; end
            if (!sram_rd_n) rlow1++;
            else if (rlow1 != 0) begin check_eq("rd_width", 32'(rlow1), 32'd1); rlow1 = 0; end
            if (a_ack) begin ack_port_q.push_back(1'b0); ack_cyc_q.push_back(cyc); end
            if (b_ack) begin ack_port_q.push_back(1'b1); ack_cyc_q.push_back(cyc); end
            aprev = a_ack; bprev = b_ack;
        end
    end

    int wlow3 = 0, rlow3 = 0;
    always @(negedge clk3) begin
        if (rst) begin
            wlow3 = 0; rlow3 = 0;
        end else begin
            check_eq("strobe_inv3", 32'({!sram3_rd_n && !sram3_wr_n,
                                         sram3_cs_n && (!sram3_rd_n || !sram3_wr_n),
                                         sram3_oe && !sram3_rd_n}), 32'd0);
            if (!sram3_wr_n) wlow3++;
            else if (wlow3 != 0) begin check_eq("wr_width3", 32'(wlow3), 32'd3); wlow3 = 0; end
            if (!sram3_rd_n) rlow3++;
            else if (rlow3 != 0) begin check_eq("rd_width3", 32'(rlow3), 32'd3); rlow3 = 0; end
        end
    end

    // Called at a falling edge; returns at the falling edge inside the ack cycle with req still high
    task automatic txn(input bit port, input bit we, input logic [17:0] addr, input logic [15:0] wd,
                       output logic [15:0] rd, output int lat);
        int t0;
        bit got;
        if (!port) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        else       begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        t0 = cyc; got = 0; rd = '0; lat = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (port ? b_ack : a_ack) begin
                got = 1; lat = cyc - t0; rd = port ? b_rdata : a_rdata;
            end
        end
        if (!got) check_eq(port ? "b_ack_timeout" : "a_ack_timeout", 32'd0, 32'd1);
        else if (we) ref_mem[addr] = wd;
        else check_eq(port ? "b_rdata" : "a_rdata", 32'(rd), 32'(ref_rd(addr)));
    endtask

    task automatic drop(input bit port);
        if (!port) a_req = 0; else b_req = 0;
    endtask

    task automatic d3_txn(input bit we, input logic [17:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat);
        int t0;
        bit got;
        a3_req = 1; a3_we = we; a3_addr = addr; a3_wdata = wd;
        t0 = cyc3; got = 0; rd = '0; lat = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk3);
            if (a3_ack) begin got = 1; lat = cyc3 - t0; rd = a3_rdata; end
        end
        if (!got) check_eq("a3_ack_timeout", 32'd0, 32'd1);
        a3_req = 0;
        @(negedge clk3);
    endtask

    logic [15:0] rdv, rd_a, rd_b;
    int          lat, lat_a, lat_b, na, nb;
    bit          seen;

    initial begin
        for (int i = 0; i < 262144; i++) begin mem1[i] = 16'h0; mem3[i] = 16'h0; end
        for (int i = 0; i < 4; i++) begin
            mem1[18'h10 + i] = 16'hA0 + 16'(i);
            ref_mem[18'h10 + i] = 16'hA0 + 16'(i);
        end
        mem3[18'h155] = 16'h5A5A;

        repeat (3) @(negedge clk);
        check_eq("rst_strobes", 32'({sram_cs_n, sram_rd_n, sram_wr_n, sram_oe, busy, a_ack, b_ack}), 32'b1110000);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_dout", 32'(sram_dout), 32'd0);
        check_eq("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        rst = 0;
        @(negedge clk);

        // Write then read back on port A
        txn(0, 1, 18'h00123, 16'hBEEF, rdv, lat);
        check_eq("t1_wr_lat", 32'(lat), 32'd3);
        check_eq("t1_rdata_hold", 32'(a_rdata), 32'd0);
        drop(0); @(negedge clk);
        check_eq("t1_mem", 32'(mem1[18'h00123]), 32'hBEEF);
        txn(0, 0, 18'h00123, 16'h0, rdv, lat);
        check_eq("t1_rd_lat", 32'(lat), 32'd3);
        check_eq("t1_rdata", 32'(rdv), 32'hBEEF);
        drop(0); @(negedge clk);

        // Simultaneous requests straight after reset: A first, B four cycles later
        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
        fork
            begin txn(0, 0, 18'h00123, 16'h0, rd_a, lat_a); drop(0); end
            begin txn(1, 1, 18'h3FFFF, 16'h1234, rd_b, lat_b); drop(1); end
        join
        check_eq("t2_a_lat", 32'(lat_a), 32'd3);
        check_eq("t2_b_after_a", 32'(lat_b - lat_a), 32'd4);
        @(negedge clk);
        txn(1, 0, 18'h3FFFF, 16'h0, rdv, lat);
        check_eq("t2_rdback", 32'(rdv), 32'h1234);
        drop(1); @(negedge clk);

        // Continuous contention alternates A,B,A,B,A,B
        ack_port_q.delete(); ack_cyc_q.delete();
        fork
            begin for (int i = 0; i < 3; i++) txn(0, 0, 18'h00123, 16'h0, rd_a, lat_a); drop(0); end
            begin for (int i = 0; i < 3; i++) txn(1, 1, 18'h00300 + 18'(i), 16'h3000 + 16'(i), rd_b, lat_b); drop(1); end
        join
        @(negedge clk);
        check_eq("t3_nacks", 32'(ack_port_q.size()), 32'd6);
        for (int i = 0; i < ack_port_q.size(); i++) begin
            check_eq("t3_order", 32'(ack_port_q[i]), 32'(i % 2));
            if (i > 0) check_eq("t3_gap", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd4);
        end

        // Back-to-back reads on A from preloaded words
        ack_port_q.delete(); ack_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            txn(0, 0, 18'h00010 + 18'(i), 16'h0, rdv, lat);
            check_eq("t4_rdata", 32'(rdv), 32'hA0 + 32'(i));
        end
        drop(0); @(negedge clk);
        check_eq("t4_nacks", 32'(ack_cyc_q.size()), 32'd4);
        for (int i = 1; i < ack_cyc_q.size(); i++)
            check_eq("t4_gap", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd4);

        // Reset in the middle of a B write
        b_req = 1; b_we = 1; b_addr = 18'h00200; b_wdata = 16'h7777;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!sram_wr_n) seen = 1;
        end
        check_eq("t5_reach_access", 32'(seen), 32'd1);
        a_req = 1; a_we = 0; a_addr = 18'h00123;
        rst = 1;
        #1;
        check_eq("t5_async_rst", 32'({sram_cs_n, sram_rd_n, sram_wr_n, sram_oe, busy, b_ack}), 32'b111000);
        @(negedge clk); @(negedge clk);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                seen = 1;
                check_eq("t5_first_grant", 32'({a_ack, b_ack}), 32'b10);
                check_eq("t5_a_rdata", 32'(a_rdata), 32'hBEEF);
            end
        end
        check_eq("t5_ack_seen", 32'(seen), 32'd1);
        a_req = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (b_ack) seen = 1;
        end
        check_eq("t5_b_served", 32'(seen), 32'd1);
        ref_mem[18'h00200] = 16'h7777;
        b_req = 0; @(negedge clk);

        // Random traffic on both ports against the reference memory
        ack_port_q.delete(); ack_cyc_q.delete();
        fork
            for (int i = 0; i < 20; i++) begin
                int g;
                txn(0, 1'($urandom_range(0, 1)), 18'h00400 + 18'($urandom_range(0, 15)), 16'($urandom), rd_a, lat_a);
                check_eq("rnd_a_lat", 32'(lat_a >= 3 && lat_a <= 8), 32'd1);
                g = $urandom_range(0, 2);
                if (g > 0 || i == 19) begin drop(0); repeat (g) @(negedge clk); end
            end
            for (int i = 0; i < 20; i++) begin
                int g;
                txn(1, 1'($urandom_range(0, 1)), 18'h00400 + 18'($urandom_range(0, 15)), 16'($urandom), rd_b, lat_b);
                check_eq("rnd_b_lat", 32'(lat_b >= 3 && lat_b <= 8), 32'd1);
                g = $urandom_range(0, 2);
                if (g > 0 || i == 19) begin drop(1); repeat (g) @(negedge clk); end
            end
        join
        repeat (3) @(negedge clk);
        na = 0; nb = 0;
        foreach (ack_port_q[i]) if (ack_port_q[i]) nb++; else na++;
        check_eq("rnd_a_acks", 32'(na), 32'd20);
        check_eq("rnd_b_acks", 32'(nb), 32'd20);

        // Longer strobe on the WAIT_CYCLES=3 instance
        @(negedge clk3);
        d3_txn(0, 18'h00155, 16'h0, rdv, lat);
        check_eq("w3_rd_lat", 32'(lat), 32'd5);
        check_eq("w3_rdata", 32'(rdv), 32'h5A5A);
        d3_txn(1, 18'h000AB, 16'hC0DE, rdv, lat);
        check_eq("w3_wr_lat", 32'(lat), 32'd5);
        d3_txn(0, 18'h000AB, 16'h0, rdv, lat);
        check_eq("w3_rdback", 32'(rdv), 32'hC0DE);
        repeat (3) @(negedge clk3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Synchronous controller that shares the board's 256Kx16 asynchronous SRAM between two requesters: port A (CPU) and port B (video/DMA).
- Arbitrates between the ports and sequences the chip strobes cs_n, rd_n and wr_n.
- Holds address and data stable around each strobe so the SRAM's 10 ns cycle and 3 ns output hold are met.
- Sits between the core/video logic and the SRAM pins (bidirectional data is split into in/out/oe).

Parameters:
- WAIT_CYCLES, 1: clock cycles the rd_n/wr_n strobe is held low. Must be >= 1, and WAIT_CYCLES x clock period must be >= 10 ns.
- ADDR_W, 18: SRAM address width.
- DATA_W, 16: SRAM data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data; valid while a_ack=1
- a_ack  out  1  port A one-cycle completion pulse
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack: same as port A, for port B
- sram_cs_n  out  1  chip select, active low
- sram_rd_n  out  1  read strobe, active low
- sram_wr_n  out  1  write strobe, active low
- sram_addr  out  ADDR_W  registered address
- sram_dout  out  DATA_W  registered write data to the SRAM
- sram_oe  out  1  1 = FPGA drives the data bus
- sram_din  in  DATA_W  read data from the SRAM
- busy  out  1  1 whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state=IDLE.
  - sram_cs_n=1, sram_rd_n=1, sram_wr_n=1, sram_oe=0.
  - sram_addr=0, sram_dout=0.
  - a_ack=0, b_ack=0; a_rdata=0, b_rdata=0; busy=0.
  - last_grant=B, so port A wins the first contention.
  - An in-flight access is abandoned and no ack is issued.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - Only one request pending: grant it.
  - Both pending: grant the port that is not last_grant (round-robin), then update last_grant.
  - On the grant edge:
    - sram_addr <= addr, sram_dout <= wdata, latch we and port id.
    - sram_cs_n <= 0; sram_oe <= we.
    - Go to SETUP.
  - No request: outputs unchanged.
- SETUP (one cycle; address stable before the strobe):
  - Read: sram_rd_n <= 0. Write: sram_wr_n <= 0.
  - cnt <= WAIT_CYCLES-1.
- ACCESS:
  - Strobe held low for WAIT_CYCLES cycles.
  - cnt != 0: decrement.
  - cnt == 0:
    - Both strobes <= 1.
    - Read: granted port's rdata <= sram_din, sampled on this edge.
    - Granted port's ack <= 1.
    - Go to DONE.
- DONE:
  - ack is high for exactly this one cycle.
  - Address, dout and oe are still held, giving hold time after the strobe rises.
  - Next edge: ack <= 0, sram_cs_n <= 1, sram_oe <= 0, go to IDLE.
- Latency: a request seen at grant edge E0 produces ack high in the cycle after edge E0+1+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- rdata holds its value until the next read on the same port.
- Requester protocol:
  - req, we, addr and wdata must stay stable from assertion through the ack cycle.
  - On the edge where ack=1, the requester may deassert req or present the next request. No double service can occur because IDLE samples one edge later.
  - The non-granted port's req is ignored until IDLE; it is never dropped.
- Signal invariants:
  - sram_rd_n and sram_wr_n are never low simultaneously.
  - Neither strobe is ever low while sram_cs_n=1.
  - sram_oe=1 only during write transactions.

Test Plan:
1. Clock 20 ns, WAIT_CYCLES=1, SRAM model attached. A writes 0x00123 <= 0xBEEF, then reads 0x00123 -> a_rdata=0xBEEF during a_ack; ack arrives 3 cycles after the grant edge; wr_n low for exactly 1 cycle; oe=1 only during the write.
2. a_req and b_req asserted in the same cycle after reset, B writing 0x3FFFF <= 0x1234 -> A is served first, then B; b_ack follows a_ack by 4 cycles; a read of 0x3FFFF returns 0x1234.
3. Both ports hold req continuously for 6 transactions -> grant order A,B,A,B,A,B; no ack cycle is missing or duplicated; no strobe overlap.
4. A holds req for 4 back-to-back reads of 0x00010..0x00013, preloaded 0xA0..0xA3 -> acks every 4 cycles with rdata 0xA0..0xA3 in order.
5. rst asserted mid-ACCESS of a B write -> within the same timestep cs_n=rd_n=wr_n=1, oe=0, busy=0, b_ack never pulses; the next contention is granted to A.
6. WAIT_CYCLES=3, clock 5 ns -> rd_n low for exactly 3 cycles (15 ns); ack 5 cycles after grant; read data correct (not X).
